// File: rtl/counter_ctrl.sv
// Command-driven front end for the interval counter: runs, stops and clears the counter over a
// valid/ready command port, auto-halts at a programmed limit and tracks time spent running.
module counter_ctrl #(
  parameter logic [31:0] DEFAULT_INTERVAL = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [31:0] limit,
  input  logic [31:0] counter_in,
  output logic [7:0]  state,
  output logic [31:0] interval,
  output logic [31:0] run_cycles,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [1:0]  st_q, st_d;
  logic [31:0] interval_d;
  logic [31:0] run_cycles_d;
  logic        done_d, err_d;
  logic        accept, auto_halt;

  assign accept    = cmd_valid && cmd_ready;
  assign auto_halt = (st_q == RUN) && (limit != 32'd0) && (counter_in >= limit);
  assign state     = {6'd0, st_q};

  always_comb begin
    st_d         = st_q;
    interval_d   = interval;
    run_cycles_d = (st_q == RUN) ? run_cycles + 32'd1 : run_cycles;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (accept && cmd_op == OP_CLEAR) begin
      // CLEAR outranks everything, including a simultaneous auto-halt.
      st_d         = IDLE;
      interval_d   = DEFAULT_INTERVAL;
      run_cycles_d = 32'd0;
    end else begin
      if (auto_halt) begin
        st_d   = HALT;
        done_d = 1'b1;
      end
      if (accept) begin
        case (cmd_op)
          OP_START: begin
            if (st_q == RUN || cmd_arg == 32'd0) begin
              err_d = 1'b1;
            end else begin
              st_d       = RUN;
              interval_d = cmd_arg;
            end
          end
          OP_STOP: begin
            if (st_q == RUN) st_d = HALT;
          end
          OP_NOP:   ;
          OP_CLEAR: ;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      interval   <= DEFAULT_INTERVAL;
      run_cycles <= 32'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      cmd_ready  <= 1'b0;
    end else begin
      st_q       <= st_d;
      interval   <= interval_d;
      run_cycles <= run_cycles_d;
      done       <= done_d;
      err        <= err_d;
      // One settle cycle after every accepted command so the counter sees each state change.
      cmd_ready  <= !accept;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: stimulus queues expected post-command/auto-halt snapshots,
// a negedge monitor pops and compares whenever the controller responds.
module tb_counter_ctrl;

  localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] limit;
  logic [31:0] counter_in;
  logic [7:0]  state;
  logic [31:0] interval;
  logic [31:0] run_cycles;
  logic        done;
  logic        err;

  counter_ctrl #(.DEFAULT_INTERVAL(32'd1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .limit      (limit),
    .counter_in (counter_in),
    .state      (state),
    .interval   (interval),
    .run_cycles (run_cycles),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Model interval counter, optionally overridden to force exact counter_in values.
  logic [31:0] cnt, phase;
  logic        ovr_en;
  logic [31:0] ovr_val;
  assign counter_in = ovr_en ? ovr_val : cnt;

  always_ff @(posedge clk) begin
    if (rst || state == 8'd0) begin
      cnt   <= 32'd0;
      phase <= 32'd0;
    end else if (state == 8'd1) begin
      if (phase + 32'd1 >= interval) begin
        cnt   <= cnt + 32'd1;
        phase <= 32'd0;
      end else begin
        phase <= phase + 32'd1;
      end
    end else begin
      phase <= 32'd0;
    end
  end

  typedef struct {
    string       name;
    logic [7:0]  st;
    logic [31:0] iv;
    logic        dn;
    logic        er;
    logic        rdy;
    logic        rc_chk;
    logic [31:0] rc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [7:0] st, input logic [31:0] iv,
                              input logic dn, input logic er, input logic rdy,
                              input logic rc_chk, input logic [31:0] rc);
    exp_t e;
    e.name = name; e.st = st; e.iv = iv; e.dn = dn; e.er = er; e.rdy = rdy;
    e.rc_chk = rc_chk; e.rc = rc;
    return e;
  endfunction

  // Monitor: a response is an accepted command (seen one cycle later) or any done/err pulse.
  logic acc_seen = 1'b0;
  always @(posedge clk) acc_seen <= cmd_valid && cmd_ready && !rst;

  always @(negedge clk) begin
    if (!rst && (acc_seen || done || err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_response", {30'd0, done, err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".state"}, {24'd0, state}, {24'd0, e.st});
        chk({e.name, ".interval"}, interval, e.iv);
        chk({e.name, ".done"}, {31'd0, done}, {31'd0, e.dn});
        chk({e.name, ".err"}, {31'd0, err}, {31'd0, e.er});
        chk({e.name, ".cmd_ready"}, {31'd0, cmd_ready}, {31'd0, e.rdy});
        if (e.rc_chk) chk({e.name, ".run_cycles"}, run_cycles, e.rc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] arg, input exp_t e);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({e.name, ".ready_wait"}, {31'd0, cmd_ready}, 32'd1);
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_arg   = 32'd0;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    chk({tag, ".state"}, {24'd0, state}, 32'd0);
    chk({tag, ".interval"}, interval, 32'd1);
    chk({tag, ".run_cycles"}, run_cycles, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".err"}, {31'd0, err}, 32'd0);
    chk({tag, ".cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = 32'd0;
    limit = 32'd0; ovr_en = 1'b0; ovr_val = 32'd0;
    repeat (3) @(posedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // START with zero interval is illegal.
    send(START, 32'd0, mk("start0", 8'd0, 32'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0));

    // Run interval 3 to limit 4: counter hits 4 on the 12th RUN edge, halt on the 13th.
    limit = 32'd4;
    send(START, 32'd3, mk("start3", 8'd1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));
    sb.push_back(mk("autohalt", 8'd2, 32'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'd13));
    begin
      int n = 0;
      while (!done && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("autohalt_seen", {31'd0, done}, 32'd1);
    end
    @(posedge clk); #1;
    chk("autohalt_counter", counter_in, 32'd4);

    // START / STOP / START resume sequence.
    limit = 32'd0;
    send(CLEAR, 32'd0, mk("clear1", 8'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));
    send(START, 32'd5, mk("start5", 8'd1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    idle(3);
    send(STOP, 32'd0, mk("stop", 8'd2, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    send(START, 32'd2, mk("start2", 8'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));

    // START while running is illegal.
    send(START, 32'd7, mk("start_in_run", 8'd1, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));

    // CLEAR coinciding with the limit wins; no done.
    limit = 32'd10; ovr_en = 1'b1; ovr_val = 32'd9;
    idle(2);
    ovr_val = 32'd10;
    send(CLEAR, 32'd0, mk("clear_vs_limit", 8'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));

    // Auto-halt coinciding with STOP still pulses done.
    ovr_val = 32'd0;
    send(START, 32'd1, mk("start1", 8'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    idle(2);
    ovr_val = 32'd10;
    send(STOP, 32'd0, mk("stop_vs_limit", 8'd2, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));

    // Auto-halt coinciding with START-in-RUN pulses both done and err.
    ovr_val = 32'd0;
    send(START, 32'd6, mk("resume6", 8'd1, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    idle(2);
    ovr_val = 32'd10;
    send(START, 32'd4, mk("start_vs_limit", 8'd2, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0));

    // Reset mid-run drops a concurrent command.
    ovr_en = 1'b0; limit = 32'd0;
    send(CLEAR, 32'd0, mk("clear2", 8'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));
    send(START, 32'd3, mk("start_pre_rst", 8'd1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    idle(3);
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = START; cmd_arg = 32'd9;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = 32'd0;
    check_reset_values("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_midrun_reset", {31'd0, cmd_ready}, 32'd1);

    idle(3);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven controller that sits in front of the interval counter and drives its `state` and `interval` inputs. It accepts start, stop and clear commands over a valid/ready handshake. It watches the counter's output and halts the counter automatically when a programmed limit is reached. It also reports run time and completion to the host-side logic.

## Interface
Parameters:
- `DEFAULT_INTERVAL`, 32'd1, interval driven while no START has been accepted since reset or CLEAR.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command this cycle.
- `cmd_op`  in  2  command opcode: 2'b00 NOP, 2'b01 START, 2'b10 STOP, 2'b11 CLEAR.
- `cmd_arg`  in  32  interval for START; ignored for other opcodes.
- `limit`  in  32  auto-halt target; 0 disables auto-halt; sampled every cycle.
- `counter_in`  in  32  counter value returned by the interval counter.
- `state`  out  8  counter state: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT.
- `interval`  out  32  interval driven to the counter.
- `run_cycles`  out  32  number of clocks spent with `state`==RUN since the last reset or CLEAR; wraps modulo 2^32.
- `done`  out  1  one-cycle pulse on auto-halt.
- `err`  out  1  one-cycle pulse on an illegal command.

## Operation
- The FSM has three states, each mapped 1:1 to the `state` output:
  - IDLE drives 8'd0.
  - RUN drives 8'd1.
  - HALT drives 8'd2.
- A command is accepted when `cmd_valid && cmd_ready` at a posedge.
- After each accepted command (including NOP), `cmd_ready` is low for exactly the next cycle. This settle cycle guarantees the counter observes every state change.
- Command rules:
  - START from IDLE or HALT: latch `interval <= cmd_arg` and go to RUN.
    - START with `cmd_arg`==0 is illegal: pulse `err`; state and interval are unchanged.
    - START from HALT resumes the count; the counter value is kept and only its sub-interval phase restarts.
  - START in RUN: illegal; pulse `err`, no other change.
  - STOP in RUN: go to HALT, no `done`.
  - STOP in IDLE or HALT: no effect, no `err`.
  - CLEAR from any state: go to IDLE, set `interval <= DEFAULT_INTERVAL` and `run_cycles <= 0`.
  - NOP: accepted, no effect.
- Auto-halt: in RUN with `limit != 0` and `counter_in >= limit` (unsigned), go to HALT and pulse `done`.
- Priority in the same cycle, highest first: CLEAR, then auto-halt, then STOP/START.
  - If auto-halt and STOP coincide, `done` still pulses.
  - If auto-halt and START-in-RUN coincide, `err` also pulses.
- `run_cycles` increments on every posedge where the registered `state` is RUN.

## Timing
- Reset values:
  - `state` 8'd0 (IDLE).
  - `interval` `DEFAULT_INTERVAL`.
  - `run_cycles` 0.
  - `done` 0, `err` 0.
  - `cmd_ready` 0 during reset, 1 in the first cycle after `rst` deasserts.
- `rst` asserted mid-run forces all of the above at the next edge. Any command presented in the same cycle is dropped.
- Command latency: a command accepted at edge N updates `state`/`interval` after edge N. `done`/`err` are high for the single cycle after edge N.
- Auto-halt latency: the condition is sampled at edge N, and `state` becomes HALT after edge N.
  - The counter is registered, so with interval 1 it can overshoot by one count (final `counter_in` = `limit`+1). This is accepted behaviour.
- All outputs are registered; there is no combinational path from inputs to outputs except none. `cmd_ready` is registered as well.

## Test plan
- Reset, then START arg=3, limit=4: `state`=1 one cycle after acceptance. Feed a model counter; `done` pulses once when `counter_in` reaches 4, then `state`=2 and `run_cycles`≈12.
- START arg=0 from IDLE: `err` pulses for 1 cycle; `state` stays 0; `interval` stays `DEFAULT_INTERVAL`.
- START arg=5, STOP, START arg=2: `state` sequence 1→2→1; `interval` goes 5 then 2; `cmd_ready` low for the cycle after each acceptance; no `done`.
- In RUN, assert CLEAR in the same cycle that `counter_in` reaches `limit`: next cycle `state`=0, `run_cycles`=0, `interval`=`DEFAULT_INTERVAL`, and `done` stays 0.
- START while RUN with limit=0: `err` pulses and `state` stays 1. Later raise `rst` mid-run: next cycle all outputs are at their reset values and `cmd_ready`=0.
